// File: rtl/milano_pkg.sv
// milano_pkg: shared decode encodings for the milano RV32I core.
// Holds opcode / function / ALU-operation enums, immediate-format selector,
// the decoded-instruction bundle type and an immediate-extraction helper.
package milano_pkg;

    localparam int MILANO_XLEN = 32;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [6:0] {
        OPC_LOAD     = 7'h03,
        OPC_MISC_MEM = 7'h0F,
        OPC_OP_IMM   = 7'h13,
        OPC_AUIPC    = 7'h17,
        OPC_STORE    = 7'h23,
        OPC_OP       = 7'h33,
        OPC_LUI      = 7'h37,
        OPC_BRANCH   = 7'h63,
        OPC_JALR     = 7'h67,
        OPC_JAL      = 7'h6F,
        OPC_SYSTEM   = 7'h73
    } opcode_e;

    // {funct7, funct3} of register-register operations (RV32I + M)
    typedef enum logic [9:0] {
        FN_ADD    = 10'h000,
        FN_SLL    = 10'h001,
        FN_SLT    = 10'h002,
        FN_SLTU   = 10'h003,
        FN_XOR    = 10'h004,
        FN_SRL    = 10'h005,
        FN_OR     = 10'h006,
        FN_AND    = 10'h007,
        FN_MUL    = 10'h008,
        FN_MULH   = 10'h009,
        FN_MULHSU = 10'h00A,
        FN_MULHU  = 10'h00B,
        FN_DIV    = 10'h00C,
        FN_DIVU   = 10'h00D,
        FN_REM    = 10'h00E,
        FN_REMU   = 10'h00F,
        FN_SUB    = 10'h100,
        FN_SRA    = 10'h105
    } function_e;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND,
        ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_opt_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef struct packed {
        logic [MILANO_XLEN-1:0] pc;
        alu_opt_e               alu_op;
        logic [4:0]             rs1;
        logic [4:0]             rs2;
        logic [4:0]             rd;
        logic                   rd_we;
        logic [MILANO_XLEN-1:0] imm;
        logic                   use_imm;
        logic                   mem_rd;
        logic                   mem_wr;
        logic                   branch;
        logic                   jump;
        logic                   illegal;
    } id_bundle_t;

    // Sign-extended immediate of the selected format; sign bit is always instr[31]
    function automatic logic [MILANO_XLEN-1:0] imm_gen(input logic [31:0] instr,
                                                       input imm_sel_e sel);
        logic [MILANO_XLEN-1:0] imm;
        case (sel)
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'h000};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = {{20{instr[31]}}, instr[31:20]};
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/milano_id_stage_decoder.sv
// milano_decoder: purely combinational RV32I decoder, instr_i -> id_bundle_t.
// Optional macro: MILANO_RV32M_EN enables decode of the M-extension ops.
module milano_decoder
    import milano_pkg::*;
(
    input  logic [31:0]            instr_i,
    input  logic [MILANO_XLEN-1:0] pc_i,
    output id_bundle_t             bundle_o
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [9:0] w_fn;
    logic       w_ill;
    logic       w_we;
    logic       w_imm_en;
    imm_sel_e   w_sel;
    id_bundle_t w_bundle;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];
    assign w_funct7 = instr_i[31:25];
    assign w_fn     = {w_funct7, w_funct3};

    // Decode fields; illegal words collapse to a harmless ADD with no side effects
    always_comb begin
        w_ill           = 1'b0;
        w_we            = 1'b0;
        w_imm_en        = 1'b0;
        w_sel           = IMM_I;
        w_bundle        = '0;
        w_bundle.pc     = pc_i;
        w_bundle.alu_op = ALU_ADD;
        w_bundle.rs1    = instr_i[19:15];
        w_bundle.rs2    = instr_i[24:20];
        w_bundle.rd     = instr_i[11:7];
        case (w_opcode)
            OPC_OP: begin
                w_we = 1'b1;
                case (w_fn)
                    FN_ADD:    w_bundle.alu_op = ALU_ADD;
                    FN_SUB:    w_bundle.alu_op = ALU_SUB;
                    FN_SLL:    w_bundle.alu_op = ALU_SLL;
                    FN_SLT:    w_bundle.alu_op = ALU_SLT;
                    FN_SLTU:   w_bundle.alu_op = ALU_SLTU;
                    FN_XOR:    w_bundle.alu_op = ALU_XOR;
                    FN_SRL:    w_bundle.alu_op = ALU_SRL;
                    FN_SRA:    w_bundle.alu_op = ALU_SRA;
                    FN_OR:     w_bundle.alu_op = ALU_OR;
                    FN_AND:    w_bundle.alu_op = ALU_AND;
`ifdef MILANO_RV32M_EN
                    FN_MUL:    w_bundle.alu_op = ALU_MUL;
                    FN_MULH:   w_bundle.alu_op = ALU_MULH;
                    FN_MULHSU: w_bundle.alu_op = ALU_MULHSU;
                    FN_MULHU:  w_bundle.alu_op = ALU_MULHU;
                    FN_DIV:    w_bundle.alu_op = ALU_DIV;
                    FN_DIVU:   w_bundle.alu_op = ALU_DIVU;
                    FN_REM:    w_bundle.alu_op = ALU_REM;
                    FN_REMU:   w_bundle.alu_op = ALU_REMU;
`endif
                    default:   w_ill = 1'b1;
                endcase
            end
            OPC_OP_IMM: begin
                w_we             = 1'b1;
                w_imm_en         = 1'b1;
                w_bundle.use_imm = 1'b1;
                case (w_funct3)
                    3'b000: w_bundle.alu_op = ALU_ADD;
                    3'b010: w_bundle.alu_op = ALU_SLT;
                    3'b011: w_bundle.alu_op = ALU_SLTU;
                    3'b100: w_bundle.alu_op = ALU_XOR;
                    3'b110: w_bundle.alu_op = ALU_OR;
                    3'b111: w_bundle.alu_op = ALU_AND;
                    3'b001: begin
                        if (w_funct7 == 7'h00) w_bundle.alu_op = ALU_SLL;
                        else                   w_ill = 1'b1;
                    end
                    default: begin
                        if (w_funct7 == 7'h00)      w_bundle.alu_op = ALU_SRL;
                        else if (w_funct7 == 7'h20) w_bundle.alu_op = ALU_SRA;
                        else                        w_ill = 1'b1;
                    end
                endcase
            end
            OPC_LOAD: begin
                w_we             = 1'b1;
                w_imm_en         = 1'b1;
                w_bundle.use_imm = 1'b1;
                w_bundle.mem_rd  = 1'b1;
                w_ill            = !(w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
            end
            OPC_STORE: begin
                w_imm_en         = 1'b1;
                w_sel            = IMM_S;
                w_bundle.use_imm = 1'b1;
                w_bundle.mem_wr  = 1'b1;
                w_ill            = (w_funct3 > 3'b010);
            end
            OPC_BRANCH: begin
                w_imm_en         = 1'b1;
                w_sel            = IMM_B;
                w_bundle.use_imm = 1'b1;
                w_bundle.branch  = 1'b1;
                w_ill            = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
            end
            OPC_JAL: begin
                w_we             = 1'b1;
                w_imm_en         = 1'b1;
                w_sel            = IMM_J;
                w_bundle.use_imm = 1'b1;
                w_bundle.jump    = 1'b1;
            end
            OPC_JALR: begin
                w_we             = 1'b1;
                w_imm_en         = 1'b1;
                w_bundle.use_imm = 1'b1;
                w_bundle.jump    = 1'b1;
                w_ill            = (w_funct3 != 3'b000);
            end
            OPC_LUI: begin
                w_we             = 1'b1;
                w_imm_en         = 1'b1;
                w_sel            = IMM_U;
                w_bundle.use_imm = 1'b1;
                w_bundle.rs1     = 5'd0;
            end
            OPC_AUIPC: begin
                w_we             = 1'b1;
                w_imm_en         = 1'b1;
                w_sel            = IMM_U;
                w_bundle.use_imm = 1'b1;
            end
            OPC_MISC_MEM: begin
                w_ill = 1'b0;
            end
            OPC_SYSTEM: begin
                w_ill = !((instr_i == INSTR_ECALL) || (instr_i == INSTR_EBREAK));
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_bundle.alu_op  = ALU_ADD;
            w_bundle.use_imm = 1'b0;
            w_bundle.mem_rd  = 1'b0;
            w_bundle.mem_wr  = 1'b0;
            w_bundle.branch  = 1'b0;
            w_bundle.jump    = 1'b0;
        end
        w_bundle.illegal = w_ill;
        w_bundle.rd_we   = w_we && !w_ill && (instr_i[11:7] != 5'd0);
        w_bundle.imm     = (w_imm_en && !w_ill) ? imm_gen(instr_i, w_sel) : '0;
    end

    assign bundle_o = w_bundle;

endmodule

// File: rtl/milano_id_stage.sv
// milano_id_stage: instruction-decode stage, one valid/ready slot between fetch and execute.
// Optional macro: MILANO_RV32M_EN (passed through to milano_decoder).
// Handshake: a word transfers on instr_valid_i && instr_ready_o, the bundle
// transfers on id_valid_o && ex_ready_i; valid never waits on ready and a
// presented bundle stays stable until taken or flushed.
module milano_id_stage
    import milano_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            flush_i,
    output logic            id_valid_o,
    input  logic            ex_ready_i,
    output logic [XLEN-1:0] pc_o,
    output alu_opt_e        alu_op_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [4:0]      rd_o,
    output logic            rd_we_o,
    output logic [XLEN-1:0] imm_o,
    output logic            use_imm_o,
    output logic            mem_rd_o,
    output logic            mem_wr_o,
    output logic            branch_o,
    output logic            jump_o,
    output logic            illegal_o
);

    logic       r_valid;
    id_bundle_t r_bundle;
    id_bundle_t w_dec;
    logic       w_accept;

    milano_decoder u_decoder (
        .instr_i  (instr_i),
        .pc_i     (pc_i),
        .bundle_o (w_dec)
    );

    // Ready depends only on the slot and downstream, never on instr_valid_i
    assign instr_ready_o = !r_valid || ex_ready_i;
    assign w_accept      = instr_valid_i && instr_ready_o && !flush_i;

    // Pipeline slot: flush wins, then accept (also covers accept+drain), then drain
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid         <= 1'b0;
            r_bundle        <= '0;
            r_bundle.pc     <= RESET_PC;
            r_bundle.alu_op <= ALU_ADD;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid  <= 1'b1;
            r_bundle <= w_dec;
        end else if (ex_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign id_valid_o = r_valid;
    assign pc_o       = r_bundle.pc;
    assign alu_op_o   = r_bundle.alu_op;
    assign rs1_o      = r_bundle.rs1;
    assign rs2_o      = r_bundle.rs2;
    assign rd_o       = r_bundle.rd;
    assign rd_we_o    = r_bundle.rd_we;
    assign imm_o      = r_bundle.imm;
    assign use_imm_o  = r_bundle.use_imm;
    assign mem_rd_o   = r_bundle.mem_rd;
    assign mem_wr_o   = r_bundle.mem_wr;
    assign branch_o   = r_bundle.branch;
    assign jump_o     = r_bundle.jump;
    assign illegal_o  = r_bundle.illegal;

endmodule

// File: tb/tb_milano_id_stage.sv
// tb_milano_id_stage: directed + randomized bench for milano_id_stage with a
// cycle-level reference model of the decode slot and an RV32I decode model.
module tb_milano_id_stage;
  import milano_pkg::*;

`ifdef MILANO_RV32M_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    alu_opt_e    alu;
    logic [4:0]  rs1, rs2, rd;
    logic        rd_we;
    logic [31:0] imm;
    logic        use_imm, mem_rd, mem_wr, branch, jump, illegal;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        instr_valid, flush, ex_ready;
  logic [31:0] instr, pc;
  logic        instr_ready_o, id_valid_o, rd_we_o, use_imm_o;
  logic        mem_rd_o, mem_wr_o, branch_o, jump_o, illegal_o;
  logic [31:0] pc_o, imm_o;
  alu_opt_e    alu_op_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;

  milano_id_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .instr_valid_i(instr_valid), .instr_ready_o(instr_ready_o),
    .instr_i(instr), .pc_i(pc), .flush_i(flush),
    .id_valid_o(id_valid_o), .ex_ready_i(ex_ready),
    .pc_o(pc_o), .alu_op_o(alu_op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .rd_o(rd_o),
    .rd_we_o(rd_we_o), .imm_o(imm_o), .use_imm_o(use_imm_o),
    .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .branch_o(branch_o),
    .jump_o(jump_o), .illegal_o(illegal_o)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic m_valid;
  exp_t m_b;
  logic [31:0] exp_q[$];   // PCs of bundles the model expects execute to take

  function automatic exp_t reset_bundle();
    exp_t e;
    e.pc = RESET_PC; e.alu = ALU_ADD; e.rs1 = '0; e.rs2 = '0; e.rd = '0;
    e.rd_we = 1'b0; e.imm = '0; e.use_imm = 1'b0; e.mem_rd = 1'b0;
    e.mem_wr = 1'b0; e.branch = 1'b0; e.jump = 1'b0; e.illegal = 1'b0;
    return e;
  endfunction

  // RV32I(+M) meaning of one word, computed from the ISA tables
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] wpc);
    exp_t e;
    alu_opt_e tab [16];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] s;
    logic legal, writes;
    tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND,
            ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    opc = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    s = {32{w[31]}};
    e = reset_bundle();
    e.pc = wpc; e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7];
    legal = 1'b1; writes = 1'b0;
    if (opc == 7'h33) begin
      writes = 1'b1;
      if (f7 == 7'h00) e.alu = tab[f3];
      else if (f7 == 7'h01 && M_EN) e.alu = tab[8 + int'(f3)];
      else if (f7 == 7'h20 && f3 == 3'd0) e.alu = ALU_SUB;
      else if (f7 == 7'h20 && f3 == 3'd5) e.alu = ALU_SRA;
      else legal = 1'b0;
    end else if (opc == 7'h13) begin
      writes = 1'b1; e.use_imm = 1'b1; e.imm = $signed(w) >>> 20;
      if (f3 == 3'd1) legal = (f7 == 7'h00);
      if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
      e.alu = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : tab[f3];
    end else if (opc == 7'h03) begin
      writes = 1'b1; e.use_imm = 1'b1; e.mem_rd = 1'b1; e.imm = $signed(w) >>> 20;
      legal = (f3 != 3'd3) && (f3 < 3'd6);
    end else if (opc == 7'h23) begin
      e.use_imm = 1'b1; e.mem_wr = 1'b1;
      e.imm = (s << 11) | 32'(w[30:25]) << 5 | 32'(w[11:7]);
      legal = (f3 <= 3'd2);
    end else if (opc == 7'h63) begin
      e.use_imm = 1'b1; e.branch = 1'b1;
      e.imm = (s << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
      legal = (f3 != 3'd2) && (f3 != 3'd3);
    end else if (opc == 7'h6F) begin
      writes = 1'b1; e.use_imm = 1'b1; e.jump = 1'b1;
      e.imm = (s << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
    end else if (opc == 7'h67) begin
      writes = 1'b1; e.use_imm = 1'b1; e.jump = 1'b1; e.imm = $signed(w) >>> 20;
      legal = (f3 == 3'd0);
    end else if (opc == 7'h37 || opc == 7'h17) begin
      writes = 1'b1; e.use_imm = 1'b1; e.imm = w & 32'hFFFF_F000;
      if (opc == 7'h37) e.rs1 = 5'd0;
    end else if (opc == 7'h0F) begin
      legal = 1'b1;
    end else if (opc == 7'h73) begin
      legal = (w == 32'h0000_0073) || (w == 32'h0010_0073);
    end else begin
      legal = 1'b0;
    end
    if (!legal) begin
      e.alu = ALU_ADD; e.use_imm = 1'b0; e.imm = '0; e.mem_rd = 1'b0;
      e.mem_wr = 1'b0; e.branch = 1'b0; e.jump = 1'b0;
    end
    e.illegal = !legal;
    e.rd_we = legal && writes && (w[11:7] != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] opcs [11];
    logic [31:0] w;
    int k;
    opcs = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    w = $urandom;
    k = $urandom_range(0, 15);
    if (k < 12) w[6:0] = opcs[$urandom_range(0, 10)];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13) begin
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        2: w[31:25] = 7'h01;
        default: ;
      endcase
    end
    if (k == 12) w = 32'h0000_0073;
    if (k == 13) w = 32'h0010_0073;
    return w;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bundle(input string tag, input exp_t e);
    chk({tag, ".pc"},      pc_o, e.pc);
    chk({tag, ".alu"},     32'(alu_op_o), 32'(e.alu));
    chk({tag, ".rs1"},     32'(rs1_o), 32'(e.rs1));
    chk({tag, ".rs2"},     32'(rs2_o), 32'(e.rs2));
    chk({tag, ".rd"},      32'(rd_o), 32'(e.rd));
    chk({tag, ".rd_we"},   32'(rd_we_o), 32'(e.rd_we));
    chk({tag, ".imm"},     imm_o, e.imm);
    chk({tag, ".use_imm"}, 32'(use_imm_o), 32'(e.use_imm));
    chk({tag, ".mem_rd"},  32'(mem_rd_o), 32'(e.mem_rd));
    chk({tag, ".mem_wr"},  32'(mem_wr_o), 32'(e.mem_wr));
    chk({tag, ".branch"},  32'(branch_o), 32'(e.branch));
    chk({tag, ".jump"},    32'(jump_o), 32'(e.jump));
    chk({tag, ".illegal"}, 32'(illegal_o), 32'(e.illegal));
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".valid"}, 32'(id_valid_o), 32'(m_valid));
    if (m_valid) check_bundle(tag, m_b);
  endtask

  // ---------------- driver ----------------
  // Called #1 after a rising edge; drives one cycle, advances the model, checks.
  task automatic step(input string tag, input logic v, input logic [31:0] w,
                      input logic [31:0] wpc, input logic er, input logic fl);
    logic m_ready;
    instr_valid = v; instr = w; pc = wpc; ex_ready = er; flush = fl;
    #1;
    m_ready = !m_valid || er;
    chk({tag, ".ready"}, 32'(instr_ready_o), 32'(m_ready));
    if (m_valid && er && !fl) begin
      chk({tag, ".drain_pc"}, pc_o, exp_q[0]);
      void'(exp_q.pop_front());
    end
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
      exp_q.delete();
    end else if (v && m_ready) begin
      m_valid = 1'b1;
      m_b = model(w, wpc);
      exp_q.push_back(wpc);
    end else if (er) begin
      m_valid = 1'b0;
    end
    #1;
    check_state(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] held_pc;
    instr_valid = 1'b0; instr = '0; pc = '0; ex_ready = 1'b0; flush = 1'b0;
    m_valid = 1'b0; m_b = reset_bundle();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 32'(id_valid_o), 32'd0);
    check_bundle("rst", reset_bundle());
    rst = 1'b0;
    @(posedge clk); #1;

    // add x3,x1,x2
    step("add", 1'b1, 32'h0020_81B3, 32'h0000_0100, 1'b1, 1'b0);
    chk("add.alu_lit", 32'(alu_op_o), 32'(ALU_ADD));
    chk("add.rd_lit", 32'(rd_o), 32'd3);
    chk("add.rs_lit", {27'd0, rs1_o}, 32'd1);
    chk("add.we_lit", 32'(rd_we_o), 32'd1);

    // sub x5,x6,x7 then addi x1,x0,-1 (back-to-back accept+drain)
    step("sub", 1'b1, 32'h4073_02B3, 32'h0000_0104, 1'b1, 1'b0);
    chk("sub.alu_lit", 32'(alu_op_o), 32'(ALU_SUB));
    step("addi", 1'b1, 32'hFFF0_0093, 32'h0000_0108, 1'b1, 1'b0);
    chk("addi.imm_lit", imm_o, 32'hFFFF_FFFF);
    chk("addi.use_imm_lit", 32'(use_imm_o), 32'd1);

    // mul x1,x2,x3
    step("mul", 1'b1, 32'h0231_00B3, 32'h0000_010C, 1'b1, 1'b0);
    chk("mul.illegal_lit", 32'(illegal_o), M_EN ? 32'd0 : 32'd1);
    chk("mul.alu_lit", 32'(alu_op_o), M_EN ? 32'(ALU_MUL) : 32'(ALU_ADD));

    // hold three cycles with fetch still offering a word
    held_pc = 32'h0000_010C;
    for (int i = 0; i < 3; i++) begin
      step("hold", 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b0, 1'b0);
      chk("hold.ready_lit", 32'(instr_ready_o), 32'd0);
      chk("hold.pc_lit", pc_o, held_pc);
    end
    step("release", 1'b1, 32'h0000_0013, 32'h0000_0200, 1'b1, 1'b0);
    chk("release.pc_lit", pc_o, 32'h0000_0200);

    // flush a held bundle while fetch offers a word
    step("prefl", 1'b1, 32'h0020_81B3, 32'h0000_0300, 1'b0, 1'b0);
    step("flush", 1'b1, 32'h0050_0113, 32'h0000_0304, 1'b0, 1'b1);
    chk("flush.valid_lit", 32'(id_valid_o), 32'd0);
    step("postfl", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // boundary words
    step("ones", 1'b1, 32'hFFFF_FFFF, 32'h0000_0400, 1'b1, 1'b0);
    chk("ones.illegal_lit", 32'(illegal_o), 32'd1);
    step("zero", 1'b1, 32'h0000_0000, 32'h0000_0404, 1'b1, 1'b0);
    chk("zero.illegal_lit", 32'(illegal_o), 32'd1);
    chk("zero.valid_lit", 32'(id_valid_o), 32'd1);
    step("beq", 1'b1, 32'hFE00_0EE3, 32'h0000_0408, 1'b1, 1'b0);
    chk("beq.branch_lit", 32'(branch_o), 32'd1);
    chk("beq.imm_lit", imm_o, 32'hFFFF_FFFC);
    step("ecall", 1'b1, 32'h0000_0073, 32'h0000_040C, 1'b1, 1'b0);
    step("lui", 1'b1, 32'h1234_50B7, 32'h0000_0410, 1'b1, 1'b0);
    chk("lui.imm_lit", imm_o, 32'h1234_5000);

    // reset while holding drops the bundle
    step("prerst", 1'b1, 32'h0020_81B3, 32'h0000_0500, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst.valid", 32'(id_valid_o), 32'd0);
    chk("midrst.pc", pc_o, RESET_PC);
    rst = 1'b0;
    m_valid = 1'b0; m_b = reset_bundle(); exp_q.delete();
    @(posedge clk); #1;
    step("noreplay", 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step("rand", $urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
